// File: rtl/pipeline_ctrl.sv
// Run/stall/flush sequencer for the 5-stage pipeline: start/drain FSM, per-stage
// valid tracking for write masking, and stall/flush/cycle/retire counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             hz_stall,
    input  logic             ctl_flow,
    input  logic             ctl_taken,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             rf_we_ok,
    output logic             mem_we_ok,
    output logic             busy,
    output logic             done,
    output logic [31:0]      cyc_cnt,
    output logic [31:0]      ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic             r_v_ifid;
    logic             r_v_idex;
    logic             r_v_exmem;
    logic             r_v_memwb;
    logic [31:0]      r_cyc_cnt;
    logic [31:0]      r_ret_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_idle;
    logic       w_fetch;
    logic       w_stall;
    logic       w_redirect;
    logic       w_drained;
    logic [1:0] w_next_state;

    assign w_idle     = (r_state == IDLE);
    assign w_fetch    = (r_state == RUN);
    assign w_stall    = hz_stall && !w_idle;
    // Stall wins over a redirect; the branch is re-evaluated once the stall clears.
    assign w_redirect = w_fetch && ctl_flow && ctl_taken && !hz_stall;
    assign w_drained  = !(r_v_ifid || r_v_idex || r_v_exmem || r_v_memwb);

    assign pc_en      = w_fetch && !w_stall;
    assign pc_sel     = w_redirect;
    assign ifid_en    = !w_idle && !w_stall;
    assign ifid_flush = w_redirect || ((r_state == DRAIN) && !w_stall);
    assign idex_flush = w_stall;
    assign rf_we_ok   = r_v_memwb;
    assign mem_we_ok  = r_v_exmem;
    assign busy       = !w_idle;
    assign done       = (r_state == DRAIN) && w_drained;

    assign cyc_cnt    = r_cyc_cnt;
    assign ret_cnt    = r_ret_cnt;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (run)       w_next_state = RUN;
            RUN:     if (!run)      w_next_state = DRAIN;
            DRAIN:   if (w_drained) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_v_ifid  <= 1'b0;
            r_v_idex  <= 1'b0;
            r_v_exmem <= 1'b0;
            r_v_memwb <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_idle) begin
                r_v_ifid  <= 1'b0;
                r_v_idex  <= 1'b0;
                r_v_exmem <= 1'b0;
                r_v_memwb <= 1'b0;
            end else begin
                r_v_memwb <= r_v_exmem;
                r_v_exmem <= r_v_idex;
                r_v_idex  <= w_stall ? 1'b0 : r_v_ifid;
                r_v_ifid  <= w_stall ? r_v_ifid : (w_fetch && !w_redirect);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_idle)
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (r_v_memwb)
                r_ret_cnt <= r_ret_cnt + 32'd1;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on the falling edge and outputs are
// sampled 1 time unit later; RUN cycle k is the k-th falling edge after entering RUN.
module tb_pipeline_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, run, hz_stall, ctl_flow, ctl_taken;
    logic          pc_en, pc_sel, ifid_en, ifid_flush, idex_flush;
    logic          rf_we_ok, mem_we_ok, busy, done;
    logic [31:0]   cyc_cnt, ret_cnt;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [4:0]    ctl;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush}
    assign ctl = {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush};

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .hz_stall(hz_stall),
        .ctl_flow(ctl_flow), .ctl_taken(ctl_taken),
        .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .rf_we_ok(rf_we_ok), .mem_we_ok(mem_we_ok), .busy(busy), .done(done),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; run = 1'b0; hz_stall = 1'b0; ctl_flow = 1'b0; ctl_taken = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy c%0d: got %b want 0", k, busy); end
            n_cmp++;
            if (ctl !== 5'b00000) begin n_bad++; $display("FAIL reset_ctl c%0d: got %b want 00000", k, ctl); end
            n_cmp++;
            if (rf_we_ok !== 1'b0) begin n_bad++; $display("FAIL reset_rf c%0d: got %b want 0", k, rf_we_ok); end
            n_cmp++;
            if ({cyc_cnt, ret_cnt, stall_cnt, flush_cnt} !== '0) begin
                n_bad++; $display("FAIL reset_cnt c%0d: got %0d/%0d/%0d/%0d want 0/0/0/0",
                                  k, cyc_cnt, ret_cnt, stall_cnt, flush_cnt);
            end
            next_cyc();
        end
    endtask

    task automatic test_run();
        logic e;
        apply_reset();
        run = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 5'b00000) begin n_bad++; $display("FAIL run_idle_ctl: got %b want 00000", ctl); end
        next_cyc();
        for (int k = 0; k < 10; k++) begin
            #1;
            n_cmp++;
            if (ctl !== 5'b10100) begin n_bad++; $display("FAIL run_ctl c%0d: got %b want 10100", k, ctl); end
            e = (k >= 4);
            n_cmp++;
            if (rf_we_ok !== e) begin n_bad++; $display("FAIL run_rf c%0d: got %b want %b", k, rf_we_ok, e); end
            e = (k >= 3);
            n_cmp++;
            if (mem_we_ok !== e) begin n_bad++; $display("FAIL run_mem c%0d: got %b want %b", k, mem_we_ok, e); end
            next_cyc();
        end
        #1;
        n_cmp++;
        if (cyc_cnt !== 32'd10) begin n_bad++; $display("FAIL run_cyc: got %0d want 10", cyc_cnt); end
        n_cmp++;
        if (ret_cnt !== 32'd6) begin n_bad++; $display("FAIL run_ret: got %0d want 6", ret_cnt); end
    endtask

    task automatic test_stall();
        logic e;
        apply_reset();
        run = 1'b1;
        next_cyc();
        repeat (6) next_cyc();
        hz_stall = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 5'b00001) begin n_bad++; $display("FAIL stall_ctl: got %b want 00001", ctl); end
        next_cyc();
        hz_stall = 1'b0;
        for (int k = 7; k < 12; k++) begin
            #1;
            e = (k != 9);
            n_cmp++;
            if (rf_we_ok !== e) begin n_bad++; $display("FAIL stall_rf c%0d: got %b want %b", k, rf_we_ok, e); end
            next_cyc();
        end
        #1;
        n_cmp++;
        if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL stall_cnt: got %0d want 1", stall_cnt); end
        n_cmp++;
        if (ret_cnt !== 32'd7) begin n_bad++; $display("FAIL stall_ret: got %0d want 7", ret_cnt); end
        n_cmp++;
        if (cyc_cnt !== 32'd12) begin n_bad++; $display("FAIL stall_cyc: got %0d want 12", cyc_cnt); end
    endtask

    task automatic test_redirect();
        logic e;
        apply_reset();
        run = 1'b1;
        next_cyc();
        repeat (6) next_cyc();
        ctl_flow = 1'b1; ctl_taken = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 5'b11110) begin n_bad++; $display("FAIL redir_ctl: got %b want 11110", ctl); end
        next_cyc();
        ctl_flow = 1'b0; ctl_taken = 1'b0;
        for (int k = 7; k < 12; k++) begin
            #1;
            e = (k != 10);
            n_cmp++;
            if (rf_we_ok !== e) begin n_bad++; $display("FAIL redir_rf c%0d: got %b want %b", k, rf_we_ok, e); end
            next_cyc();
        end
        #1;
        n_cmp++;
        if (flush_cnt !== 4'd1) begin n_bad++; $display("FAIL redir_cnt: got %0d want 1", flush_cnt); end
        ctl_flow = 1'b1; ctl_taken = 1'b1; hz_stall = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 5'b00001) begin n_bad++; $display("FAIL redir_stall_ctl: got %b want 00001", ctl); end
        next_cyc();
        ctl_flow = 1'b0; hz_stall = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 5'b10100) begin n_bad++; $display("FAIL redir_noflow_ctl: got %b want 10100", ctl); end
        next_cyc();
        ctl_taken = 1'b0;
        #1;
        n_cmp++;
        if (flush_cnt !== 4'd1) begin n_bad++; $display("FAIL redir_cnt_hold: got %0d want 1", flush_cnt); end
        n_cmp++;
        if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL redir_stall_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_drain();
        logic e;
        apply_reset();
        run = 1'b1;
        next_cyc();
        repeat (6) next_cyc();
        run = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 5'b10100) begin n_bad++; $display("FAIL drain_last_run_ctl: got %b want 10100", ctl); end
        next_cyc();
        #1;
        n_cmp++;
        if ({ctl, done} !== 6'b001100) begin n_bad++; $display("FAIL drain_d0: got %b want 001100", {ctl, done}); end
        next_cyc();
        hz_stall = 1'b1;
        #1;
        n_cmp++;
        if ({ctl, done} !== 6'b000010) begin n_bad++; $display("FAIL drain_d1_stall: got %b want 000010", {ctl, done}); end
        next_cyc();
        hz_stall = 1'b0;
        for (int d = 2; d < 5; d++) begin
            #1;
            e = (d == 4);
            n_cmp++;
            if ({busy, done} !== {1'b1, e}) begin
                n_bad++; $display("FAIL drain_done d%0d: got busy=%b done=%b want busy=1 done=%b", d, busy, done, e);
            end
            n_cmp++;
            if (rf_we_ok !== !e) begin n_bad++; $display("FAIL drain_rf d%0d: got %b want %b", d, rf_we_ok, !e); end
            next_cyc();
        end
        #1;
        n_cmp++;
        if ({busy, done, ctl} !== 7'b0) begin n_bad++; $display("FAIL drain_idle: got %b want 0000000", {busy, done, ctl}); end
        n_cmp++;
        if (cyc_cnt !== 32'd12) begin n_bad++; $display("FAIL drain_cyc: got %0d want 12", cyc_cnt); end
        n_cmp++;
        if (ret_cnt !== 32'd7) begin n_bad++; $display("FAIL drain_ret: got %0d want 7", ret_cnt); end
        n_cmp++;
        if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL drain_stall_cnt: got %0d want 1", stall_cnt); end
        next_cyc();
        run = 1'b1;
        #1;
        n_cmp++;
        if ({busy, ctl} !== 6'b0) begin n_bad++; $display("FAIL restart_idle: got %b want 000000", {busy, ctl}); end
        next_cyc();
        #1;
        n_cmp++;
        if ({busy, ctl} !== 6'b110100) begin n_bad++; $display("FAIL restart_run: got %b want 110100", {busy, ctl}); end
    endtask

    task automatic test_saturation();
        apply_reset();
        run = 1'b1;
        next_cyc();
        next_cyc();
        next_cyc();
        hz_stall = 1'b1;
        for (int k = 2; k < 22; k++) begin
            if (k == 16) begin
                #1;
                n_cmp++;
                if (stall_cnt !== 4'd14) begin n_bad++; $display("FAIL sat_pre: got %0d want 14", stall_cnt); end
            end
            next_cyc();
        end
        hz_stall = 1'b0;
        #1;
        n_cmp++;
        if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
    endtask

    // Continues from the end of test_saturation (RUN cycle 22).
    task automatic test_async_reset();
        next_cyc();
        next_cyc();
        #1;
        n_cmp++;
        if ({cyc_cnt, mem_we_ok} !== {32'd24, 1'b1}) begin
            n_bad++; $display("FAIL areset_pre: got cyc=%0d mem=%b want cyc=24 mem=1", cyc_cnt, mem_we_ok);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, ctl, rf_we_ok, mem_we_ok} !== 9'b0) begin
            n_bad++; $display("FAIL areset_ctl: got %b want 000000000", {busy, done, ctl, rf_we_ok, mem_we_ok});
        end
        n_cmp++;
        if ({cyc_cnt, ret_cnt, stall_cnt, flush_cnt} !== '0) begin
            n_bad++; $display("FAIL areset_cnt: got %0d/%0d/%0d/%0d want 0/0/0/0",
                              cyc_cnt, ret_cnt, stall_cnt, flush_cnt);
        end
        next_cyc();
        rst = 1'b0;
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; hz_stall = 1'b0; ctl_flow = 1'b0; ctl_taken = 1'b0;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_drain();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Run/stall/flush sequencer for the 5-stage pipeline. Consumes the hazard unit's `stall` and branch-resolve signals and drives PC and IF/ID enables, the IF/ID and ID/EX bubble inserts, and the redirect select. Tracks a valid bit per pipeline register so writes from bubbles and squashed instructions are masked. Also runs the start/drain state machine and the performance counters.

## Interface
- CNT_W, 16, width of the saturating stall and flush counters.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = fetch and execute, 0 = stop fetching and drain.
- hz_stall  in  1  load-use / jump-operand hazard from the hazard unit; same-cycle.
- ctl_flow  in  1  IF/ID holds j/jr/bgt with operands ready (calc_branch).
- ctl_taken  in  1  resolved redirect for the instruction in IF/ID; ignored unless ctl_flow=1.
- pc_en  out  1  PC register load enable.
- pc_sel  out  1  1 = PC loads the branch/jump target; 0 = PC+4.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP instead of the fetched word (requires ifid_en=1).
- idex_flush  out  1  ID/EX loads a NOP.
- rf_we_ok  out  1  = valid_memwb; ANDed with regfile write enable.
- mem_we_ok  out  1  = valid_exmem; ANDed with data-memory write enable.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on DRAIN→IDLE.
- cyc_cnt  out  32  cycles spent in RUN or DRAIN; wraps.
- ret_cnt  out  32  retired instructions (cycles with valid_memwb=1); wraps.
- stall_cnt  out  CNT_W  cycles in which a stall was applied; saturates at all-ones.
- flush_cnt  out  CNT_W  taken redirects; saturates at all-ones.

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE → RUN when run=1. RUN → DRAIN when run=0. DRAIN → IDLE when all four valid bits are 0, with done=1 that cycle. run in DRAIN is ignored: the drain always completes, then IDLE→RUN on the next cycle if run is still 1.
- fetch = (state==RUN).
- stall = hz_stall and state != IDLE.
- redirect = fetch and ctl_flow and ctl_taken and not hz_stall. Stall has priority: a redirect presented during a stall is not taken and is re-evaluated on the next cycle.
- Combinational outputs:
  - pc_en = fetch and not stall.
  - pc_sel = redirect.
  - ifid_en = (state != IDLE) and not stall.
  - ifid_flush = redirect, or (state==DRAIN and not stall).
  - idex_flush = stall.
- In IDLE, pc_en, pc_sel, ifid_en, ifid_flush and idex_flush are all 0.
- Valid pipeline, updated on each clock:
  - valid_memwb ← valid_exmem.
  - valid_exmem ← valid_idex.
  - valid_idex ← stall ? 0 : valid_ifid.
  - valid_ifid ← stall ? valid_ifid : (fetch and not redirect).
- In IDLE all valid bits load 0.
- Counters: each of cyc_cnt, ret_cnt, stall_cnt and flush_cnt increments by one on a cycle in which its condition holds.

## Timing
- Reset values: state=IDLE; valid bits 0; all counters 0; done=0; busy=0; all enables/flushes/selects 0.
- Reset asserted mid-operation: immediate return to these values. In-flight instructions are lost; writes are masked because the valid bits clear.
- Control outputs are combinational from registered state and the same-cycle inputs; there are no registered control delays.
- Start latency: the first fetched instruction has valid_ifid=1 one cycle after entering RUN, and rf_we_ok=1 four cycles after entering RUN, absent stalls.
- Load-use stall: one stall cycle holds PC and IF/ID and inserts exactly one ID/EX bubble.
- Taken redirect: one squashed slot (IF/ID bubble). The PC loads the target on that edge.
- Drain length is at most 4 cycles plus the number of stall cycles seen during DRAIN.
- Counters saturate (stall/flush) or wrap (cyc/ret) with no error flag.

## Test plan
- Reset with run=0 for 5 cycles → busy=0, pc_en=0, all counters 0, rf_we_ok=0.
- run=1, no hazards, 10 cycles → pc_en=1 throughout RUN; rf_we_ok rises on cycle 4 after entry; ret_cnt=6 and cyc_cnt=10 at the end.
- hz_stall=1 for one cycle in steady RUN → that cycle pc_en=0, ifid_en=0, idex_flush=1; rf_we_ok shows exactly one 0 three cycles later; stall_cnt=1.
- ctl_flow=ctl_taken=1 for one cycle → pc_sel=1, ifid_flush=1; one masked slot in rf_we_ok; flush_cnt=1. Repeat with hz_stall=1 the same cycle → pc_sel=0, flush_cnt unchanged.
- Drop run mid-stream with a hz_stall pulse during DRAIN → DRAIN lasts 5 cycles, done pulses once, state IDLE. Raise run again → RUN the next cycle.
- Force stall_cnt near saturation (CNT_W=4, 20 stall cycles) → stall_cnt holds at 15. Assert rst mid-RUN → all outputs return to their reset values asynchronously.
